// File: rtl/fpu_wb_arbiter.sv
// Writeback arbiter for one FPU lane: per-source skid registers and a round-robin
// grant that presents at most one register write per cycle.

module fpu_wb_skid (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flag,
  input  logic [4:0]  i_rt,
  input  logic [31:0] i_data,
  input  logic        i_gnt,
  output logic        o_v,
  output logic        o_cand,
  output logic        o_coll,
  output logic [4:0]  o_rt,
  output logic [31:0] o_data
);
  logic        r_v;
  logic [4:0]  r_rt;
  logic [31:0] r_data;

  // A grant drains the skid, or consumes the input directly when the skid is empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v    <= 1'b0;
      r_rt   <= '0;
      r_data <= '0;
    end else if (i_gnt) begin
      r_v <= 1'b0;
    end else if (i_flag && !r_v) begin
      r_v    <= 1'b1;
      r_rt   <= i_rt;
      r_data <= i_data;
    end
  end

  assign o_v    = r_v;
  assign o_cand = r_v | i_flag;
  assign o_coll = r_v & i_flag;
  assign o_rt   = r_v ? r_rt : i_rt;
  assign o_data = r_v ? r_data : i_data;
endmodule

module fpu_wb_arbiter #(
  parameter int N_SRC    = 4,
  parameter int STALL_TH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_interlock,
  input  logic [N_SRC-1:0]           i_in_flag,
  input  logic [5*N_SRC-1:0]         i_in_rt,
  input  logic [32*N_SRC-1:0]        i_in_data,
  output logic                       o_wb_flag,
  output logic [4:0]                 o_wb_rt,
  output logic [31:0]                o_wb_data,
  output logic [$clog2(N_SRC+1)-1:0] o_pending,
  output logic                       o_stall_req,
  output logic                       o_overflow
);
  localparam int PW = $clog2(N_SRC);
  localparam int CW = $clog2(N_SRC+1);
  localparam logic [PW:0] NS = (PW+1)'(N_SRC);

  logic [N_SRC-1:0]            w_v, w_cand, w_coll, w_gnt_oh;
  logic [N_SRC-1:0][4:0]       w_cand_rt;
  logic [N_SRC-1:0][31:0]      w_cand_data;
  logic [PW-1:0]               r_ptr, w_gnt, w_idx;
  logic                        w_any, w_fire;
  logic                        r_wb_flag, r_ovf;
  logic [4:0]                  r_wb_rt;
  logic [31:0]                 r_wb_data;
  logic [CW-1:0]               w_pend;

  function automatic logic [PW-1:0] f_wrap(input logic [PW:0] s);
    return (s >= NS) ? PW'(s - NS) : s[PW-1:0];
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    fpu_wb_skid u_skid (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_flag (i_in_flag[i]),
      .i_rt   (i_in_rt[5*i +: 5]),
      .i_data (i_in_data[32*i +: 32]),
      .i_gnt  (w_gnt_oh[i]),
      .o_v    (w_v[i]),
      .o_cand (w_cand[i]),
      .o_coll (w_coll[i]),
      .o_rt   (w_cand_rt[i]),
      .o_data (w_cand_data[i])
    );
    assign w_gnt_oh[i] = w_fire && (w_gnt == PW'(i));
  end

  // Walk from the farthest offset back to ptr so the nearest candidate wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      w_idx = f_wrap({1'b0, r_ptr} + (PW+1)'(k));
      if (w_cand[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_fire = w_any & ~i_interlock;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb_flag <= 1'b0;
      r_wb_rt   <= '0;
      r_wb_data <= '0;
      r_ptr     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (|w_coll);
      if (!i_interlock) begin
        r_wb_flag <= w_any;
        if (w_any) begin
          r_wb_rt   <= w_cand_rt[w_gnt];
          r_wb_data <= w_cand_data[w_gnt];
          r_ptr     <= f_wrap({1'b0, w_gnt} + (PW+1)'(1));
        end
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < N_SRC; i++) w_pend = w_pend + CW'(w_v[i]);
  end

  assign o_wb_flag   = r_wb_flag;
  assign o_wb_rt     = r_wb_rt;
  assign o_wb_data   = r_wb_data;
  assign o_pending   = w_pend;
  assign o_stall_req = (w_pend >= CW'(STALL_TH));
  assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed bench for fpu_wb_arbiter (N_SRC=4, STALL_TH=2).

module tb_fpu_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, interlock;
  logic [3:0]  in_flag;
  logic [19:0] in_rt;
  logic [127:0] in_data;
  logic        wb_flag, stall_req, overflow;
  logic [4:0]  wb_rt;
  logic [31:0] wb_data;
  logic [2:0]  pending;
  int checks = 0;
  int errors = 0;

  fpu_wb_arbiter #(.N_SRC(4), .STALL_TH(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_interlock(interlock),
    .i_in_flag(in_flag), .i_in_rt(in_rt), .i_in_data(in_data),
    .o_wb_flag(wb_flag), .o_wb_rt(wb_rt), .o_wb_data(wb_data),
    .o_pending(pending), .o_stall_req(stall_req), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    in_flag = '0;
    in_rt   = '0;
    in_data = '0;
  endtask

  task automatic set_src(input int i, input logic [4:0] rt, input logic [31:0] d);
    in_flag[i]       = 1'b1;
    in_rt[5*i +: 5]  = rt;
    in_data[32*i +: 32] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1; interlock = 1'b0; clr_in();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({wb_flag, wb_rt, wb_data} !== 38'd0) begin
      errors++; $display("FAIL reset_wb: got %b/%0d/%h want 0/0/0", wb_flag, wb_rt, wb_data);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({wb_flag, pending, stall_req, overflow} !== 6'd0) begin
        errors++; $display("FAIL idle_%0d: got flag=%b pend=%0d stall=%b ovf=%b want 0", c, wb_flag, pending, stall_req, overflow);
      end
    end
  endtask

  task automatic test_single;
    set_src(2, 5'd7, 32'h3F800000);
    tick(); clr_in();
    checks++;
    if ({wb_flag, wb_rt, wb_data} !== {1'b1, 5'd7, 32'h3F800000}) begin
      errors++; $display("FAIL single_t1: got %b/%0d/%h want 1/7/3f800000", wb_flag, wb_rt, wb_data);
    end
    tick();
    checks++;
    if ({wb_flag, wb_rt} !== {1'b0, 5'd7}) begin
      errors++; $display("FAIL single_t2: got flag=%b rt=%0d want 0/7", wb_flag, wb_rt);
    end
  endtask

  task automatic test_collision;
    logic [4:0] exp_rt[4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [2:0] exp_p[4]  = '{3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i+1), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 4; c++) begin
      tick(); clr_in();
      checks++;
      if ({wb_flag, wb_rt, wb_data, pending, stall_req} !==
          {1'b1, exp_rt[c], 32'hA000_0000 + 32'(c), exp_p[c], exp_p[c] >= 3'd2}) begin
        errors++; $display("FAIL coll_%0d: got %b/%0d/%h pend=%0d stall=%b want rt=%0d pend=%0d",
                           c, wb_flag, wb_rt, wb_data, pending, stall_req, exp_rt[c], exp_p[c]);
      end
    end
    tick();
    checks++;
    if (wb_flag !== 1'b0) begin
      errors++; $display("FAIL coll_end: got flag=%b want 0", wb_flag);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    set_src(1, 5'd11, 32'h1111);
    tick(); clr_in();
    set_src(0, 5'd20, 32'h2000);
    set_src(2, 5'd22, 32'h2222);
    tick(); clr_in();
    checks++;
    if ({wb_flag, wb_rt, wb_data, pending} !== {1'b1, 5'd22, 32'h2222, 3'd1}) begin
      errors++; $display("FAIL rr_first: got %b/%0d/%h pend=%0d want 1/22/2222 pend=1", wb_flag, wb_rt, wb_data, pending);
    end
    tick();
    checks++;
    if ({wb_flag, wb_rt, wb_data, pending} !== {1'b1, 5'd20, 32'h2000, 3'd0}) begin
      errors++; $display("FAIL rr_second: got %b/%0d/%h pend=%0d want 1/20/2000 pend=0", wb_flag, wb_rt, wb_data, pending);
    end
    tick();
  endtask

  task automatic test_interlock;
    interlock = 1'b1;
    set_src(3, 5'd9, 32'hDEAD_BEEF);
    for (int c = 0; c < 4; c++) begin
      tick(); clr_in();
      checks++;
      if ({wb_flag, pending} !== {1'b0, 3'd1}) begin
        errors++; $display("FAIL ilk_%0d: got flag=%b pend=%0d want 0/1", c, wb_flag, pending);
      end
    end
    interlock = 1'b0;
    tick();
    checks++;
    if ({wb_flag, wb_rt, wb_data, pending} !== {1'b1, 5'd9, 32'hDEAD_BEEF, 3'd0}) begin
      errors++; $display("FAIL ilk_release: got %b/%0d/%h pend=%0d want 1/9/deadbeef pend=0", wb_flag, wb_rt, wb_data, pending);
    end
    // A pending write must be held, not repeated or dropped, across a freeze.
    interlock = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({wb_flag, wb_rt} !== {1'b1, 5'd9}) begin
        errors++; $display("FAIL ilk_hold_%0d: got flag=%b rt=%0d want 1/9", c, wb_flag, wb_rt);
      end
    end
    interlock = 1'b0;
    tick();
    checks++;
    if (wb_flag !== 1'b0) begin
      errors++; $display("FAIL ilk_hold_end: got flag=%b want 0", wb_flag);
    end
  endtask

  task automatic test_overflow;
    interlock = 1'b1;
    set_src(0, 5'd5, 32'hAAAA_0005);
    tick(); clr_in();
    checks++;
    if ({pending, overflow} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL ovf_park: got pend=%0d ovf=%b want 1/0", pending, overflow);
    end
    set_src(0, 5'd6, 32'hBBBB_0006);
    tick(); clr_in();
    checks++;
    if ({pending, overflow} !== {3'd1, 1'b1}) begin
      errors++; $display("FAIL ovf_set: got pend=%0d ovf=%b want 1/1", pending, overflow);
    end
    interlock = 1'b0;
    tick();
    checks++;
    if ({wb_flag, wb_rt, wb_data} !== {1'b1, 5'd5, 32'hAAAA_0005}) begin
      errors++; $display("FAIL ovf_emit: got %b/%0d/%h want 1/5/aaaa0005", wb_flag, wb_rt, wb_data);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({wb_flag, pending, overflow} !== {1'b0, 3'd0, 1'b1}) begin
        errors++; $display("FAIL ovf_after_%0d: got flag=%b pend=%0d ovf=%b want 0/0/1", c, wb_flag, pending, overflow);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_reset_mid;
    interlock = 1'b1;
    set_src(1, 5'd13, 32'h1313);
    set_src(2, 5'd14, 32'h1414);
    tick(); clr_in();
    checks++;
    if ({pending, stall_req} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL mid_park: got pend=%0d stall=%b want 2/1", pending, stall_req);
    end
    rst = 1'b1; tick(); rst = 1'b0; interlock = 1'b0;
    checks++;
    if ({wb_flag, pending, stall_req} !== {1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL mid_rst: got flag=%b pend=%0d stall=%b want 0/0/0", wb_flag, pending, stall_req);
    end
    tick();
    checks++;
    if ({wb_flag, wb_rt} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL mid_after: got flag=%b rt=%0d want 0/0", wb_flag, wb_rt);
    end
    // rt=0 is an ordinary destination; ptr restarts at 0 so source 0 wins.
    set_src(3, 5'd0, 32'h0000_0303);
    set_src(0, 5'd3, 32'h0000_0003);
    tick(); clr_in();
    checks++;
    if ({wb_flag, wb_rt, wb_data} !== {1'b1, 5'd3, 32'h3}) begin
      errors++; $display("FAIL mid_ptr: got %b/%0d/%h want 1/3/3", wb_flag, wb_rt, wb_data);
    end
    tick();
    checks++;
    if ({wb_flag, wb_rt, wb_data} !== {1'b1, 5'd0, 32'h303}) begin
      errors++; $display("FAIL rt_zero: got %b/%0d/%h want 1/0/303", wb_flag, wb_rt, wb_data);
    end
  endtask

  initial begin
    rst = 1'b1; interlock = 1'b0; clr_in();
    #1;
    test_reset();
    test_single();
    test_collision();
    test_round_robin();
    test_interlock();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
